ex_mem_skid_pipeline: RTL and testbench

- Next-generation EX/MEM stage register that replaces the free-running latch with a valid/ready handshake and a 2-entry skid buffer.
- Lets MEM back-pressure EX without a combinational ready path, and supports a hazard-unit flush.
- Output control bits are gated to 0 whenever the stage holds no valid instruction.
- Carries a saturating stall-cycle counter for performance monitoring.

---
 rtl/ex_mem_skid_pipeline_if.sv | 55 +++++
 rtl/ex_mem_skid_pipeline.sv | 177 +++++++++++++++++
 tb/tb_ex_mem_skid_pipeline.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_skid_pipeline_if.sv
// EX/MEM stage bus: the EX-side handshake and payload, the MEM-side
// handshake and payload, the flush request and the stall monitor.
// The stage itself connects through the slave modport; the driver of the
// EX side and the consumer of the MEM side use the master modport.
interface ex_mem_skid_pipeline_if #(
  parameter int INST_WIDTH          = 32,
  parameter int INST_ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH          = 32,
  parameter int REGISTER_ADDR_WIDTH = 5,
  parameter int STALL_CNT_WIDTH     = 16
);
  logic                                flush_i;
  logic                                in_valid_i;
  logic                                in_ready_o;
  logic        [INST_WIDTH-1:0]        INST_i;
  logic                                reg_write_i;
  logic                                mem_write_i;
  logic        [1:0]                   result_sel_i;
  logic signed [DATA_WIDTH-1:0]        alu_res_i;
  logic        [REGISTER_ADDR_WIDTH-1:0] rd_i;
  logic signed [DATA_WIDTH-1:0]        write_data_i;
  logic        [INST_ADDR_WIDTH-1:0]   PC_plus_4_i;
  logic        [2:0]                   funct3_i;

  logic        [INST_WIDTH-1:0]        INST_o;
  logic                                reg_write_o;
  logic                                mem_write_o;
  logic        [1:0]                   result_sel_o;
  logic signed [DATA_WIDTH-1:0]        alu_res_o;
  logic        [REGISTER_ADDR_WIDTH-1:0] rd_o;
  logic signed [DATA_WIDTH-1:0]        write_data_o;
  logic        [INST_ADDR_WIDTH-1:0]   PC_plus_4_o;
  logic        [2:0]                   funct3_o;
  logic                                out_valid_o;
  logic                                out_ready_i;
  logic        [STALL_CNT_WIDTH-1:0]   stall_cnt_o;

  modport slave (
    input  flush_i, in_valid_i, INST_i, reg_write_i, mem_write_i,
           result_sel_i, alu_res_i, rd_i, write_data_i, PC_plus_4_i,
           funct3_i, out_ready_i,
    output in_ready_o, INST_o, reg_write_o, mem_write_o, result_sel_o,
           alu_res_o, rd_o, write_data_o, PC_plus_4_o, funct3_o,
           out_valid_o, stall_cnt_o
  );

  modport master (
    output flush_i, in_valid_i, INST_i, reg_write_i, mem_write_i,
           result_sel_i, alu_res_i, rd_i, write_data_i, PC_plus_4_i,
           funct3_i, out_ready_i,
    input  in_ready_o, INST_o, reg_write_o, mem_write_o, result_sel_o,
           alu_res_o, rd_o, write_data_o, PC_plus_4_o, funct3_o,
           out_valid_o, stall_cnt_o
  );
endinterface

// File: rtl/ex_mem_skid_pipeline.sv
// EX/MEM stage register with valid/ready handshake and a two-entry skid
// buffer. in_ready_o depends only on local state (and reset), so MEM can
// stall EX without a combinational ready path through this stage. The main
// register drives the outputs; the skid register catches the one beat that
// EX may push while MEM is stalling. Write enables are gated off whenever
// no valid beat is held, and a saturating counter tracks stalled cycles.
module ex_mem_skid_pipeline #(
  parameter int INST_WIDTH          = 32,
  parameter int INST_ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH          = 32,
  parameter int REGISTER_ADDR_WIDTH = 5,
  parameter int STALL_CNT_WIDTH     = 16
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rst,
  ex_mem_skid_pipeline_if.slave  bus
);

  typedef struct packed {
    logic [INST_WIDTH-1:0]          inst;
    logic                           reg_write;
    logic                           mem_write;
    logic [1:0]                     result_sel;
    logic [DATA_WIDTH-1:0]          alu_res;
    logic [REGISTER_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]          write_data;
    logic [INST_ADDR_WIDTH-1:0]     pc_plus_4;
    logic [2:0]                     funct3;
  } payload_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Counter step that sticks at all-ones instead of wrapping.
  function automatic logic [STALL_CNT_WIDTH-1:0] sat_inc(
    input logic [STALL_CNT_WIDTH-1:0] v
  );
    if (&v) begin
      return v;
    end
    return v + STALL_CNT_WIDTH'(1);
  endfunction

  state_t   r_state;
  state_t   w_state_next;
  payload_t w_in_payload;
  payload_t r_main_p1;
  payload_t r_skid_p1;
  logic     w_in_ready;
  logic     w_out_valid;
  logic     w_accept;
  logic     w_release;
  logic     w_load_main_in;
  logic     w_load_main_skid;
  logic     w_load_skid;
  logic     w_stall;
  logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;

  // ---- p0: handshake decode from current state ----
  assign w_in_ready  = (r_state != ST_FULL) && !cpu_rst;
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_accept    = bus.in_valid_i && w_in_ready;
  assign w_release   = w_out_valid && bus.out_ready_i;
  assign w_stall     = w_out_valid && !bus.out_ready_i;

  // Gather the EX-side fields into one payload word.
  always_comb begin
    w_in_payload            = '0;
    w_in_payload.inst       = bus.INST_i;
    w_in_payload.reg_write  = bus.reg_write_i;
    w_in_payload.mem_write  = bus.mem_write_i;
    w_in_payload.result_sel = bus.result_sel_i;
    w_in_payload.alu_res    = $unsigned(bus.alu_res_i);
    w_in_payload.rd         = bus.rd_i;
    w_in_payload.write_data = $unsigned(bus.write_data_i);
    w_in_payload.pc_plus_4  = bus.PC_plus_4_i;
    w_in_payload.funct3     = bus.funct3_i;
  end

  // Next-state and register-load decode; a flush overrides every load.
  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_next   = ST_ONE;
          w_load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_release) begin
          w_load_main_in = 1'b1;
        end else if (w_accept) begin
          w_state_next = ST_FULL;
          w_load_skid  = 1'b1;
        end else if (w_release) begin
          w_state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_release) begin
          w_state_next     = ST_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_EMPTY;
      end
    endcase
    if (bus.flush_i) begin
      w_state_next     = ST_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  // ---- p1: state and storage registers ----
  // State register; reset dominates flush, which is folded into next-state.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Main register: loads a fresh beat or promotes the skid beat.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_main_p1 <= '0;
    end else if (w_load_main_in) begin
      r_main_p1 <= w_in_payload;
    end else if (w_load_main_skid) begin
      r_main_p1 <= r_skid_p1;
    end
  end

  // Skid register: catches the beat accepted while MEM is stalling.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_skid_p1 <= '0;
    end else if (w_load_skid) begin
      r_skid_p1 <= w_in_payload;
    end
  end

  // Stall counter: counts cycles a valid beat waits on MEM; flush ignored.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  // ---- output drive from the main register ----
  assign bus.in_ready_o   = w_in_ready;
  assign bus.out_valid_o  = w_out_valid;
  assign bus.INST_o       = r_main_p1.inst;
  assign bus.reg_write_o  = r_main_p1.reg_write & w_out_valid;
  assign bus.mem_write_o  = r_main_p1.mem_write & w_out_valid;
  assign bus.result_sel_o = r_main_p1.result_sel;
  assign bus.alu_res_o    = $signed(r_main_p1.alu_res);
  assign bus.rd_o         = r_main_p1.rd;
  assign bus.write_data_o = $signed(r_main_p1.write_data);
  assign bus.PC_plus_4_o  = r_main_p1.pc_plus_4;
  assign bus.funct3_o     = r_main_p1.funct3;
  assign bus.stall_cnt_o  = r_stall_cnt;

endmodule

// File: tb/tb_ex_mem_skid_pipeline.sv
// Directed bench for ex_mem_skid_pipeline: a vector table covering reset,
// streaming, back-pressure, bubble gating, flush and mid-run reset, then a
// hand-written saturation sequence on a second instance with a 4-bit counter.
// Secondary payload fields are derived from alu_res so one value checks all.
module tb_ex_mem_skid_pipeline;

  logic cpu_clk;
  logic cpu_rst;
  logic cpu_rst2;
  int   checks;
  int   errors;

  ex_mem_skid_pipeline_if #(.STALL_CNT_WIDTH(16)) bus ();
  ex_mem_skid_pipeline_if #(.STALL_CNT_WIDTH(4))  bus2 ();

  ex_mem_skid_pipeline #(.STALL_CNT_WIDTH(16)) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus     (bus)
  );

  ex_mem_skid_pipeline #(.STALL_CNT_WIDTH(4)) dut_sat (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst2),
    .bus     (bus2)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic        rst, fl, iv, rdy;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        rw, mw;
    logic        e_ov, e_ir;
    logic [4:0]  e_rd;
    logic [31:0] e_alu;
    logic        e_rw, e_mw;
    logic [15:0] e_sc;
  } vec_t;

  vec_t vecs[27];

  function automatic vec_t mk(
    input logic rst, fl, iv, rdy, input logic [4:0] rd, input logic [31:0] alu,
    input logic rw, mw, input logic e_ov, e_ir, input logic [4:0] e_rd,
    input logic [31:0] e_alu, input logic e_rw, e_mw, input logic [15:0] e_sc
  );
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.rdy = rdy; v.rd = rd; v.alu = alu;
    v.rw = rw; v.mw = mw; v.e_ov = e_ov; v.e_ir = e_ir; v.e_rd = e_rd;
    v.e_alu = e_alu; v.e_rw = e_rw; v.e_mw = e_mw; v.e_sc = e_sc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    cpu_rst          = v.rst;
    bus.flush_i      = v.fl;
    bus.in_valid_i   = v.iv;
    bus.out_ready_i  = v.rdy;
    bus.rd_i         = v.rd;
    bus.alu_res_i    = v.alu;
    bus.reg_write_i  = v.rw;
    bus.mem_write_i  = v.mw;
    bus.INST_i       = {v.alu[15:0], v.alu[15:0]};
    bus.write_data_i = v.alu << 1;
    bus.PC_plus_4_i  = {v.alu[29:0], 2'b00};
    bus.funct3_i     = v.alu[2:0];
    bus.result_sel_i = v.alu[1:0];
  endtask

  task automatic check_vec(input int i, input vec_t v);
    logic [31:0] e_inst, e_wd, e_pc;
    e_inst = {v.e_alu[15:0], v.e_alu[15:0]};
    e_wd   = v.e_alu << 1;
    e_pc   = {v.e_alu[29:0], 2'b00};
    chk($sformatf("v%0d.out_valid", i), 64'(bus.out_valid_o), 64'(v.e_ov));
    chk($sformatf("v%0d.in_ready", i),  64'(bus.in_ready_o),  64'(v.e_ir));
    chk($sformatf("v%0d.rd", i),        64'(bus.rd_o),        64'(v.e_rd));
    chk($sformatf("v%0d.alu_res", i),   64'($unsigned(bus.alu_res_o)), 64'(v.e_alu));
    chk($sformatf("v%0d.reg_write", i), 64'(bus.reg_write_o), 64'(v.e_rw));
    chk($sformatf("v%0d.mem_write", i), 64'(bus.mem_write_o), 64'(v.e_mw));
    chk($sformatf("v%0d.stall_cnt", i), 64'(bus.stall_cnt_o), 64'(v.e_sc));
    chk($sformatf("v%0d.inst", i),      64'(bus.INST_o),      64'(e_inst));
    chk($sformatf("v%0d.write_data", i), 64'($unsigned(bus.write_data_o)), 64'(e_wd));
    chk($sformatf("v%0d.pc_plus_4", i), 64'(bus.PC_plus_4_o), 64'(e_pc));
    chk($sformatf("v%0d.funct3", i),    64'(bus.funct3_o),    64'(v.e_alu[2:0]));
    chk($sformatf("v%0d.result_sel", i), 64'(bus.result_sel_o), 64'(v.e_alu[1:0]));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cpu_rst  = 1'b1;
    cpu_rst2 = 1'b1;
    drive(mk(1,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
    bus2.flush_i = 1'b0; bus2.in_valid_i = 1'b0; bus2.out_ready_i = 1'b0;
    bus2.INST_i = '0; bus2.reg_write_i = 1'b0; bus2.mem_write_i = 1'b0;
    bus2.result_sel_i = '0; bus2.alu_res_i = '0; bus2.rd_i = '0;
    bus2.write_data_i = '0; bus2.PC_plus_4_i = '0; bus2.funct3_i = '0;

    //            rst fl iv rdy rd  alu          rw mw | ov ir rd  alu          rw mw sc
    vecs[0]  = mk(1, 0, 0, 0,  0,  0,           0, 0,   0, 0, 0,  0,           0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 1,  0,  0,           0, 0,   0, 1, 0,  0,           0, 0, 0);
    vecs[2]  = mk(0, 0, 1, 1,  5,  1,           1, 0,   1, 1, 5,  1,           1, 0, 0);
    vecs[3]  = mk(0, 0, 1, 1,  6,  2,           1, 0,   1, 1, 6,  2,           1, 0, 0);
    vecs[4]  = mk(0, 0, 1, 1,  7,  3,           0, 0,   1, 1, 7,  3,           0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 1,  0,  0,           0, 0,   0, 1, 7,  3,           0, 0, 0);
    vecs[6]  = mk(0, 0, 1, 0,  3,  10,          1, 0,   1, 1, 3,  10,          1, 0, 0);
    vecs[7]  = mk(0, 0, 1, 0,  4,  11,          0, 1,   1, 0, 3,  10,          1, 0, 1);
    vecs[8]  = mk(0, 0, 1, 0,  9,  12,          1, 1,   1, 0, 3,  10,          1, 0, 2);
    vecs[9]  = mk(0, 0, 0, 1,  0,  0,           0, 0,   1, 1, 4,  11,          0, 1, 2);
    vecs[10] = mk(0, 0, 0, 1,  0,  0,           0, 0,   0, 1, 4,  11,          0, 0, 2);
    vecs[11] = mk(0, 0, 0, 0,  0,  0,           0, 0,   0, 1, 4,  11,          0, 0, 2);
    vecs[12] = mk(0, 0, 0, 0,  0,  0,           0, 0,   0, 1, 4,  11,          0, 0, 2);
    vecs[13] = mk(0, 0, 0, 0,  0,  0,           0, 0,   0, 1, 4,  11,          0, 0, 2);
    vecs[14] = mk(0, 0, 1, 0,  1,  20,          1, 0,   1, 1, 1,  20,          1, 0, 2);
    vecs[15] = mk(0, 0, 1, 0,  2,  21,          1, 0,   1, 0, 1,  20,          1, 0, 3);
    vecs[16] = mk(0, 1, 1, 0,  8,  22,          1, 1,   0, 1, 1,  20,          0, 0, 4);
    vecs[17] = mk(0, 0, 0, 1,  0,  0,           0, 0,   0, 1, 1,  20,          0, 0, 4);
    vecs[18] = mk(0, 0, 1, 0,  11, 30,          1, 0,   1, 1, 11, 30,          1, 0, 4);
    vecs[19] = mk(0, 1, 1, 1,  12, 31,          1, 0,   0, 1, 11, 30,          0, 0, 4);
    vecs[20] = mk(0, 0, 0, 1,  0,  0,           0, 0,   0, 1, 11, 30,          0, 0, 4);
    vecs[21] = mk(0, 0, 1, 0,  13, 40,          1, 1,   1, 1, 13, 40,          1, 1, 4);
    vecs[22] = mk(0, 0, 1, 0,  14, 41,          0, 0,   1, 0, 13, 40,          1, 1, 5);
    vecs[23] = mk(1, 0, 1, 0,  15, 42,          1, 1,   0, 0, 0,  0,           0, 0, 0);
    vecs[24] = mk(0, 0, 0, 0,  0,  0,           0, 0,   0, 1, 0,  0,           0, 0, 0);
    vecs[25] = mk(0, 0, 1, 1,  15, 32'hFFFFFFFB, 1, 0,  1, 1, 15, 32'hFFFFFFFB, 1, 0, 0);
    vecs[26] = mk(0, 0, 0, 1,  0,  0,           0, 0,   0, 1, 15, 32'hFFFFFFFB, 0, 0, 0);

    for (int i = 0; i < 27; i++) begin
      drive(vecs[i]);
      tick();
      check_vec(i, vecs[i]);
    end

    // Saturation on the 4-bit counter instance.
    cpu_rst2 = 1'b1;
    tick();
    chk("sat.reset_cnt", 64'(bus2.stall_cnt_o), 64'd0);
    cpu_rst2 = 1'b0;
    bus2.in_valid_i  = 1'b1;
    bus2.out_ready_i = 1'b0;
    bus2.rd_i        = 5'd2;
    bus2.alu_res_i   = 32'sd55;
    tick();
    chk("sat.valid", 64'(bus2.out_valid_o), 64'd1);
    chk("sat.cnt0", 64'(bus2.stall_cnt_o), 64'd0);
    bus2.in_valid_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("sat.cnt%0d", k), 64'(bus2.stall_cnt_o), 64'((k > 15) ? 15 : k));
    end
    chk("sat.hold_alu", 64'($unsigned(bus2.alu_res_o)), 64'd55);
    chk("sat.hold_rd", 64'(bus2.rd_o), 64'd2);
    bus2.out_ready_i = 1'b1;
    tick();
    chk("sat.drained", 64'(bus2.out_valid_o), 64'd0);
    chk("sat.cnt_kept", 64'(bus2.stall_cnt_o), 64'd15);
    cpu_rst2 = 1'b1;
    tick();
    chk("sat.cnt_cleared", 64'(bus2.stall_cnt_o), 64'd0);
    chk("sat.ready_in_reset", 64'(bus2.in_ready_o), 64'd0);
    cpu_rst2 = 1'b0;
    #1;
    chk("sat.ready_after_reset", 64'(bus2.in_ready_o), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
